// File: rtl/ccu_wb_sequencer.sv
// Dirty-line writeback sequencer: one AW, Beats W beats, one B per request; aw_valid one cycle after accept.
// Optional CCU_WB_SEQ_STATS_EN adds a saturating writeback counter; all valids hold until their ready.
module ccu_wb_sequencer #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineWidth = 512,
  parameter int IdWidth   = 4,
  parameter int WbId      = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [LineWidth-1:0]   req_data_i,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [AddrWidth-1:0]   aw_addr_o,
  output logic [7:0]             aw_len_o,
  output logic [2:0]             aw_size_o,
  output logic [IdWidth-1:0]     aw_id_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  output logic [DataWidth-1:0]   w_data_o,
  output logic [DataWidth/8-1:0] w_strb_o,
  output logic                   w_last_o,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [1:0]             b_resp_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [15:0]            wb_count_o
);

  localparam int Beats     = LineWidth / DataWidth;
  localparam int AxSize    = $clog2(DataWidth / 8);
  localparam int LineAlign = $clog2(LineWidth / 8);
  localparam int Align     = (LineAlign > AxSize) ? LineAlign : AxSize;
  localparam int CntWidth  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntWidth-1:0]  LastBeat  = CntWidth'(Beats - 1);
  localparam logic [AddrWidth-1:0] AlignMask = ~((AddrWidth'(1) << Align) - AddrWidth'(1));

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W,
    B
  } state_e;

  state_e                state, state_nxt;
  logic [CntWidth-1:0]   cnt, cnt_nxt;
  logic [AddrWidth-1:0]  addr_q;
  logic [LineWidth-1:0]  line_q;
  logic                  req_accept;
  logic [DataWidth-1:0]  beat_slice [Beats];
  logic                  unused_resp;

  // Only SLVERR/DECERR matter, both of which carry bit 1.
  assign unused_resp = b_resp_i[0];

  for (genvar g = 0; g < Beats; g++) begin : g_slice
    assign beat_slice[g] = line_q[g*DataWidth +: DataWidth];
  end

  assign req_accept = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      line_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (req_accept) begin
        addr_q <= req_addr_i & AlignMask;
        line_q <= req_data_i;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    req_ready_o = 1'b0;
    aw_valid_o  = 1'b0;
    w_valid_o   = 1'b0;
    w_last_o    = 1'b0;
    b_ready_o   = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = AW;
      end
      AW: begin
        aw_valid_o = 1'b1;
        if (aw_ready_i) state_nxt = W;
      end
      W: begin
        w_valid_o = 1'b1;
        w_last_o  = (cnt == LastBeat);
        if (w_ready_i) begin
          if (cnt == LastBeat) begin
            cnt_nxt   = '0;
            state_nxt = B;
          end else begin
            cnt_nxt = cnt + CntWidth'(1);
          end
        end
      end
      B: begin
        b_ready_o = 1'b1;
        if (b_valid_i) begin
          done_o    = 1'b1;
          err_o     = b_resp_i[1];
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign aw_addr_o = addr_q;
  assign aw_len_o  = 8'(Beats - 1);
  assign aw_size_o = 3'(AxSize);
  assign aw_id_o   = IdWidth'(WbId);
  assign w_data_o  = beat_slice[cnt];
  assign w_strb_o  = '1;
  assign busy_o    = (state != IDLE);

`ifdef CCU_WB_SEQ_STATS_EN
  logic [15:0] wb_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_count <= '0;
    end else if (done_o && (wb_count != 16'hFFFF)) begin
      wb_count <= wb_count + 16'd1;
    end
  end

  assign wb_count_o = wb_count;
`else
  assign wb_count_o = '0;
`endif

endmodule

// File: tb/tb_ccu_wb_sequencer.sv
// Randomized bench for ccu_wb_sequencer: a transaction-level scoreboard predicts every output each cycle.
module tb_ccu_wb_sequencer;
  localparam int DW         = 64;
  localparam int LW         = 512;
  localparam int BEATS      = LW / DW;
  localparam int LINE_BYTES = LW / 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [63:0]  req_addr;
  logic [511:0] req_data;
  logic         aw_valid, aw_ready;
  logic [63:0]  aw_addr;
  logic [7:0]   aw_len;
  logic [2:0]   aw_size;
  logic [3:0]   aw_id;
  logic         w_valid, w_ready, w_last;
  logic [63:0]  w_data;
  logic [7:0]   w_strb;
  logic         b_valid, b_ready;
  logic [1:0]   b_resp;
  logic         busy, done, err;
  logic [15:0]  wb_count;

  ccu_wb_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr), .req_data_i(req_data),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_len_o(aw_len),
    .aw_size_o(aw_size), .aw_id_o(aw_id),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
    .busy_o(busy), .done_o(done), .err_o(err), .wb_count_o(wb_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Scoreboard: the one outstanding writeback and how far it has progressed.
  bit           m_busy, m_aw_done;
  int           m_beats, m_count, m_done_evts;
  logic [63:0]  m_addr;
  logic [511:0] m_line;
  int           s_aw_stall, s_w_hs, s_last_beat, s_done, s_err;
  logic [63:0]  s_aw_addr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_count();
`ifdef CCU_WB_SEQ_STATS_EN
    return m_count;
`else
    return 0;
`endif
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic monitor();
    bit e_aw, e_w, e_b, e_done;
    logic [511:0] sh;
    if (rst) begin
      m_busy = 0; m_aw_done = 0; m_beats = 0; m_count = 0;
    end
    e_aw   = m_busy && !m_aw_done;
    e_w    = m_busy && m_aw_done && (m_beats < BEATS);
    e_b    = m_busy && (m_beats == BEATS);
    e_done = e_b && (b_valid === 1'b1);
    check_eq("req_ready", req_ready, !m_busy);
    check_eq("busy", busy, m_busy);
    check_eq("aw_valid", aw_valid, e_aw);
    check_eq("w_valid", w_valid, e_w);
    check_eq("w_last", w_last, e_w && (m_beats == BEATS - 1));
    check_eq("b_ready", b_ready, e_b);
    check_eq("done", done, e_done);
    check_eq("err", err, e_done && b_resp[1]);
    check_eq("wb_count", wb_count, exp_count());
    if (e_aw) begin
      check_eq("aw_addr", aw_addr, (m_addr / LINE_BYTES) * LINE_BYTES);
      check_eq("aw_len", aw_len, BEATS - 1);
      check_eq("aw_size", aw_size, 3);
      check_eq("aw_id", aw_id, 0);
    end
    if (e_w) begin
      sh = m_line >> (m_beats * DW);
      check_eq("w_data", w_data, sh[63:0]);
      check_eq("w_strb", w_strb, 8'hFF);
    end
    if (!rst) begin
      if (aw_valid && !aw_ready) s_aw_stall++;
      if (aw_valid && aw_ready) s_aw_addr = aw_addr;
      if (w_valid && w_ready) begin
        s_w_hs++;
        if (w_last) s_last_beat = s_w_hs;
      end
      if (done) s_done++;
      if (err) s_err++;
      if (!m_busy && req_valid) begin
        m_busy = 1; m_aw_done = 0; m_beats = 0;
        m_addr = req_addr; m_line = req_data;
      end else if (e_aw && aw_ready) begin
        m_aw_done = 1;
      end else if (e_w && w_ready) begin
        m_beats++;
      end else if (e_done) begin
        m_busy = 0;
        if (m_count < 65535) m_count++;
        m_done_evts++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [63:0] addr, input logic [511:0] data,
                         input int p_aw, input int p_w, input int p_b, input int aw_hold,
                         input bit w_toggle, input bit rand_resp, input logic [1:0] resp,
                         input int rst_beat);
    int start, guard, hold;
    start = m_done_evts; guard = 0; hold = aw_hold;
    s_aw_stall = 0; s_w_hs = 0; s_last_beat = 0; s_done = 0; s_err = 0; s_aw_addr = '0;
    req_addr = addr; req_data = data; w_ready = 1'b0;
    while (m_done_evts == start && guard < 400) begin
      req_valid = m_busy ? 1'($urandom % 2) : 1'b1;
      if (m_busy && !m_aw_done && hold > 0) begin
        aw_ready = 1'b0;
        hold--;
      end else begin
        aw_ready = ($urandom % 100) < p_aw;
      end
      w_ready = w_toggle ? ~w_ready : (($urandom % 100) < p_w);
      b_valid = ($urandom % 100) < p_b;
      b_resp  = rand_resp ? 2'($urandom) : resp;
      if (rst_beat >= 0 && m_busy && m_aw_done && m_beats == rst_beat) begin
        rst = 1'b1; req_valid = 1'b0;
        tick();
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_w_valid", w_valid, 0);
        tick();
        rst = 1'b0;
        return;
      end
      tick();
      guard++;
    end
    req_valid = 1'b0;
    if (guard >= 400) begin
      check_eq("txn_timeout", 1, 0);
    end else begin
      check_eq("beat_handshakes", s_w_hs, BEATS);
      check_eq("last_on_beat", s_last_beat, BEATS);
      check_eq("done_cycles", s_done, 1);
      check_eq("err_cycles", s_err, (!rand_resp && resp[1]) ? 1 : (rand_resp ? s_err : 0));
    end
  endtask

  initial begin
    int p_aw, p_w, p_b, hold, rb;
    rst = 1'b1; req_valid = 0; req_addr = '0; req_data = '0;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = '0;
    m_busy = 0; m_aw_done = 0; m_beats = 0; m_count = 0; m_done_evts = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_txn(64'h1234_5678, rand_line(), 100, 100, 100, 0, 0, 0, 2'b00, -1);
    check_eq("ex_aw_addr", s_aw_addr, 64'h1234_5640);
    check_eq("ex_aw_no_stall", s_aw_stall, 0);
    run_txn({$urandom, $urandom}, rand_line(), 100, 100, 100, 5, 0, 0, 2'b00, -1);
    check_eq("aw_stall_cycles", s_aw_stall, 5);
    run_txn({$urandom, $urandom}, rand_line(), 100, 0, 100, 0, 1, 0, 2'b00, -1);
`ifdef CCU_WB_SEQ_STATS_EN
    check_eq("wb_count_3", wb_count, 3);
`else
    check_eq("wb_count_3", wb_count, 0);
`endif
    run_txn({$urandom, $urandom}, rand_line(), 100, 100, 60, 0, 0, 0, 2'b10, -1);
    run_txn({$urandom, $urandom}, rand_line(), 100, 100, 60, 0, 0, 0, 2'b00, -1);
    run_txn({$urandom, $urandom}, rand_line(), 100, 100, 100, 0, 0, 0, 2'b00, 3);
    run_txn({$urandom, $urandom}, rand_line(), 100, 100, 100, 0, 0, 0, 2'b00, -1);

    for (int n = 0; n < 150; n++) begin
      p_aw = $urandom_range(30, 100);
      p_w  = $urandom_range(30, 100);
      p_b  = $urandom_range(30, 100);
      hold = ($urandom % 4 == 0) ? $urandom_range(1, 6) : 0;
      rb   = ($urandom % 20 == 0) ? $urandom_range(0, BEATS - 1) : -1;
      run_txn({$urandom, $urandom}, rand_line(), p_aw, p_w, p_b, hold, 0, 1, 2'b00, rb);
      repeat ($urandom_range(0, 2)) begin
        b_valid = 1'($urandom % 2);
        b_resp  = 2'($urandom);
        tick();
      end
    end
    b_valid = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
